pwm_scheduler: RTL and testbench

- Consumes the five configuration registers written over SPI (output enables, PWM enables, duty cycle) and drives the 16 chip outputs.
- Free-running 8-bit PWM period counter, clocked by a prescaled tick.
- Config changes are double-buffered into shadow registers and applied only at a period boundary, so every period is glitch-free.
- Sits between the SPI register bank and the output pins.

---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_prescaler.sv | 27 ++
 rtl/pwm_scheduler.sv | 121 ++++++++++++
 tb/tb_pwm_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM output scheduler.
package pwm_pkg;

    typedef enum logic [0:0] {
        IDLE,
        RUN
    } state_e;

    localparam int unsigned PWM_CNT_W = 8;
    localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
    localparam int unsigned NUM_OUT = 16;

endpackage

// File: rtl/pwm_prescaler.sv
// Divides the system clock into a one-clock PWM tick every CLK_DIV clocks.
module pwm_prescaler #(
    parameter int unsigned CLK_DIV = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;

    assign tick = en && (div_q == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            div_q <= '0;
        end else if (en) begin
            div_q <= tick ? '0 : div_q + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_scheduler.sv
// Drives the 16 chip outputs from double-buffered enable/duty config; config
// only takes effect at PWM period boundaries so each period is glitch-free.
module pwm_scheduler
    import pwm_pkg::*;
#(
    parameter int unsigned CLK_DIV = 12,
    parameter int unsigned CNT_W   = PWM_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         en_reg_out_7_0,
    input  logic [7:0]         en_reg_out_15_8,
    input  logic [7:0]         en_reg_pwm_7_0,
    input  logic [7:0]         en_reg_pwm_15_8,
    input  logic [CNT_W-1:0]   pwm_duty_cycle,
    input  logic               cfg_update,
    output logic [NUM_OUT-1:0] out,
    output logic               period_start,
    output logic               busy
);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   duty_s_q;
    logic [NUM_OUT-1:0] en_out_s_q;
    logic [NUM_OUT-1:0] en_pwm_s_q;
    logic [NUM_OUT-1:0] out_q;
    logic               pending_q;
    logic               period_start_q;

    logic [NUM_OUT-1:0] live_en_out;
    logic [NUM_OUT-1:0] live_en_pwm;
    logic [NUM_OUT-1:0] pin_d;
    logic               lvl;
    logic               tick;
    logic               boundary;
    logic               reload;

    assign live_en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign live_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    pwm_prescaler #(
        .CLK_DIV(CLK_DIV)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (state_q == RUN),
        .clr (state_q == IDLE),
        .tick(tick)
    );

    assign boundary = tick && (cnt_q == {CNT_W{1'b1}});
    // A cfg_update landing on the boundary itself is applied right away.
    assign reload   = boundary && (pending_q || cfg_update);

    // Full-scale duty is forced high so 0xFF has no 1/256 dropout.
    always_comb begin
        pin_d = '0;
        lvl   = (duty_s_q == DUTY_FULL) || (cnt_q < duty_s_q);
        for (int i = 0; i < int'(NUM_OUT); i++) begin
            pin_d[i] = en_out_s_q[i] && (!en_pwm_s_q[i] || lvl);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            duty_s_q       <= '0;
            en_out_s_q     <= '0;
            en_pwm_s_q     <= '0;
            out_q          <= '0;
            pending_q      <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            period_start_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    out_q <= '0;
                    cnt_q <= '0;
                    if (live_en_out != '0) begin
                        en_out_s_q     <= live_en_out;
                        en_pwm_s_q     <= live_en_pwm;
                        duty_s_q       <= pwm_duty_cycle;
                        pending_q      <= 1'b0;
                        state_q        <= RUN;
                        period_start_q <= 1'b1;
                    end
                end
                RUN: begin
                    out_q <= pin_d;
                    if (tick) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (cfg_update) begin
                        pending_q <= 1'b1;
                    end
                    if (reload) begin
                        en_out_s_q <= live_en_out;
                        en_pwm_s_q <= live_en_pwm;
                        duty_s_q   <= pwm_duty_cycle;
                        pending_q  <= 1'b0;
                    end
                    if (reload && (live_en_out == '0)) begin
                        state_q <= IDLE;
                        out_q   <= '0;
                        cnt_q   <= '0;
                    end else if (boundary) begin
                        period_start_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;
    assign busy         = (state_q == RUN);

endmodule

// File: tb/tb_pwm_scheduler.sv
// Scoreboard bench: stimulus queues expected per-period pin high-times, a
// monitor measures each period window and compares when it closes.
module tb_pwm_scheduler;

    localparam int unsigned CLK_DIV = 2;
    localparam int PERIOD = 256 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  eo_lo = '0, eo_hi = '0, ep_lo = '0, ep_hi = '0, duty = '0;
    logic        cfg_update = 1'b0;
    logic [15:0] out;
    logic        period_start;
    logic        busy;

    always #5 clk = ~clk;

    pwm_scheduler #(
        .CLK_DIV(CLK_DIV)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en_reg_out_7_0 (eo_lo),
        .en_reg_out_15_8(eo_hi),
        .en_reg_pwm_7_0 (ep_lo),
        .en_reg_pwm_15_8(ep_hi),
        .pwm_duty_cycle (duty),
        .cfg_update     (cfg_update),
        .out            (out),
        .period_start   (period_start),
        .busy           (busy)
    );

    // Per pin: full_pins high whole period, pwm_pins high pwm_clks, rest low.
    typedef struct {
        string       name;
        logic [15:0] full_pins;
        logic [15:0] pwm_pins;
        int          pwm_clks;
    } win_t;

    win_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, req, req);
        end
    endtask

    task automatic push(input string name, input logic [15:0] full, input logic [15:0] pwm,
                        input int clks, input int n);
        win_t w;
        for (int k = 0; k < n; k++) begin
            w.name = $sformatf("%s_w%0d", name, k);
            w.full_pins = full;
            w.pwm_pins = pwm;
            w.pwm_clks = clks;
            exp_q.push_back(w);
        end
    endtask

    task automatic drive(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        {eo_hi, eo_lo} = eo;
        {ep_hi, ep_lo} = ep;
        duty = d;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns 1 time unit into the clock after the n-th period_start pulse.
    task automatic wait_ps(input int n);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < 2 * PERIOD * n + 16) begin
            @(negedge clk);
            cyc++;
            if (period_start === 1'b1) seen++;
        end
        if (seen < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_period_start: got %0d pulses, expected %0d", seen, n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cfg_update = 1'b0;
        drive(16'h0000, 16'h0000, 8'h00);
        step(3);
        rst = 1'b0;
        step(1);
    endtask

    // Monitor: a window spans the pins' response to one counter period, i.e.
    // starts one clock after period_start since out lags the counter by one.
    int   cnt_hi[16];
    int   win_len = 0;
    bit   in_win = 1'b0;
    bit   ps_dly = 1'b0;
    win_t cur;

    always @(negedge clk) begin
        if (rst || !busy) begin
            in_win = 1'b0;
        end else begin
            if (ps_dly) begin
                if (in_win) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_window: got window of %0d clocks, expected none",
                                 win_len);
                    end else begin
                        cur = exp_q.pop_front();
                        check({cur.name, "_len"}, win_len, PERIOD);
                        for (int i = 0; i < 16; i++) begin
                            check($sformatf("%s_pin%0d", cur.name, i), cnt_hi[i],
                                  cur.full_pins[i] ? PERIOD : (cur.pwm_pins[i] ? cur.pwm_clks : 0));
                        end
                    end
                end
                in_win = 1'b1;
                win_len = 0;
                for (int i = 0; i < 16; i++) cnt_hi[i] = 0;
            end
            if (in_win) begin
                win_len++;
                for (int i = 0; i < 16; i++) cnt_hi[i] += int'(out[i]);
            end
        end
        ps_dly = period_start;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ps_cnt, busy_cnt, out_cnt;

        // Reset state, then a long idle stretch with no output enables.
        do_reset();
        check("reset_out", out, 0);
        check("reset_busy", busy, 0);
        check("reset_period_start", period_start, 0);
        ps_cnt = 0; busy_cnt = 0; out_cnt = 0;
        repeat (1000) begin
            @(negedge clk);
            ps_cnt += int'(period_start);
            busy_cnt += int'(busy);
            out_cnt += int'(out != 16'h0);
        end
        check("idle_period_start_pulses", ps_cnt, 0);
        check("idle_busy_cycles", busy_cnt, 0);
        check("idle_out_cycles", out_cnt, 0);
        step(1);

        // Single constant-on pin.
        push("const_pin0", 16'h0001, 16'h0000, 0, 2);
        drive(16'h0001, 16'h0000, 8'h00);
        wait_ps(1);
        check("const_busy", busy, 1);
        check("const_out", out, 16'h0001);
        wait_ps(2);
        step(2);
        do_reset();

        // 25% duty on the low byte.
        push("duty40", 16'h0000, 16'h00FF, 128, 3);
        drive(16'h00FF, 16'h00FF, 8'h40);
        wait_ps(4);
        step(2);
        do_reset();

        // Duty 0: PWM pins dark, non-PWM pins full on.
        push("duty00", 16'h00FF, 16'hFF00, 0, 3);
        drive(16'hFFFF, 16'hFF00, 8'h00);
        wait_ps(4);
        step(2);
        do_reset();

        // Duty 0xFF: every PWM pin high for whole period.
        push("dutyFF", 16'h0000, 16'hFFFF, PERIOD, 3);
        drive(16'hFFFF, 16'hFFFF, 8'hFF);
        wait_ps(4);
        step(2);
        do_reset();

        // Mid-period update is deferred; update on the boundary applies at once.
        push("mid_old", 16'hF0F0, 16'h0F0F, 128, 1);
        push("mid_new", 16'hF0F0, 16'h0F0F, 384, 2);
        push("bnd_new", 16'hF0F0, 16'h0F0F, 64, 1);
        drive(16'hFFFF, 16'h0F0F, 8'h40);
        wait_ps(1);
        step(31);
        check("mid_cnt_at_update", dut.cnt_q, 8'h10);
        drive(16'hFFFF, 16'h0F0F, 8'hC0);
        cfg_update = 1'b1;
        step(1);
        cfg_update = 1'b0;
        wait_ps(2);
        step(510);
        drive(16'hFFFF, 16'h0F0F, 8'h20);
        cfg_update = 1'b1;
        step(1);
        cfg_update = 1'b0;
        wait_ps(2);
        step(2);

        // Pending reload with no output enables returns to IDLE.
        drive(16'h0000, 16'h0F0F, 8'h20);
        cfg_update = 1'b1;
        step(1);
        cfg_update = 1'b0;
        step(507);
        check("off_pre_busy", busy, 1);
        check("off_pre_out", out, 16'hF0F0);
        step(1);
        check("off_busy", busy, 0);
        check("off_out", out, 16'h0000);
        step(20);
        check("off_stays_idle", busy, 0);
        do_reset();

        // Reset mid-period at cnt 0x80.
        drive(16'h00FF, 16'h00FF, 8'hFF);
        wait_ps(1);
        step(255);
        check("rst_pre_cnt", dut.cnt_q, 8'h80);
        check("rst_pre_out", out, 16'h00FF);
        rst = 1'b1;
        step(1);
        check("rst_out", out, 16'h0000);
        check("rst_busy", busy, 0);
        check("rst_period_start", period_start, 0);
        check("rst_cnt", dut.cnt_q, 0);
        check("rst_state", int'(dut.state_q), int'(pwm_pkg::IDLE));
        check("rst_pending", dut.pending_q, 0);
        drive(16'h0000, 16'h0000, 8'h00);
        step(2);
        rst = 1'b0;
        step(5);
        check("rst_release_busy", busy, 0);

        check("leftover_windows", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
